// File: rtl/rdma_rx_pkg.sv
// rdma_rx_pkg: RDMA receive-path opcodes, header layout and parser FSM states
package rdma_rx_pkg;
    localparam logic [7:0] OP_WRITE_FIRST  = 8'h06;
    localparam logic [7:0] OP_WRITE_MIDDLE = 8'h07;
    localparam logic [7:0] OP_WRITE_LAST   = 8'h08;
    localparam logic [7:0] OP_WRITE_ONLY   = 8'h0A;
    localparam logic [7:0] OP_WRITE_TEST   = 8'h01;
    localparam int HDR_WORDS  = 5;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 24;
    localparam int OFFSET_MSB = 15;
    localparam int OFFSET_LSB = 0;
    typedef enum logic [1:0] {ST_HDR, ST_EMIT, ST_PAYLOAD, ST_DRAIN} state_e;
    function automatic logic is_write_opcode(input logic [7:0] op);
        return op inside {OP_WRITE_FIRST, OP_WRITE_MIDDLE, OP_WRITE_LAST, OP_WRITE_ONLY, OP_WRITE_TEST};
    endfunction
endpackage

// File: rtl/rx_header_parser.sv
// rx_header_parser: parses a 5-word RDMA header and forwards WRITE payload to the S2MM stream.
// Defining RX_PARSER_STATS_EN adds saturating pkts/writes/drops/errors counters.
module rx_header_parser
    import rdma_rx_pkg::*;
#(
    parameter int C_DATA_WIDTH      = 32,
    parameter int RDMA_OPCODE_WIDTH = 8,
    parameter int RDMA_ADDR_WIDTH   = 64,
    parameter int RDMA_RKEY_WIDTH   = 32,
    parameter int RDMA_LENGTH_WIDTH = 32,
    parameter int OFFSET_LENGTH     = 16
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [C_DATA_WIDTH-1:0]      s_axis_rx_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]    s_axis_rx_tkeep,
    input  logic                         s_axis_rx_tvalid,
    output logic                         s_axis_rx_tready,
    input  logic                         s_axis_rx_tlast,
    output logic [C_DATA_WIDTH-1:0]      m_axis_s2mm_tdata,
    output logic [C_DATA_WIDTH/8-1:0]    m_axis_s2mm_tkeep,
    output logic                         m_axis_s2mm_tvalid,
    input  logic                         m_axis_s2mm_tready,
    output logic                         m_axis_s2mm_tlast,
    output logic                         header_valid,
    output logic [RDMA_OPCODE_WIDTH-1:0] rdma_opcode,
    output logic [RDMA_ADDR_WIDTH-1:0]   rdma_remote_addr,
    output logic [RDMA_RKEY_WIDTH-1:0]   rdma_rkey,
    output logic [RDMA_LENGTH_WIDTH-1:0] rdma_length,
    output logic [OFFSET_LENGTH-1:0]     fragment_offset,
    output logic                         parse_error
`ifdef RX_PARSER_STATS_EN
    ,
    output logic [31:0]                  stat_pkts,
    output logic [31:0]                  stat_writes,
    output logic [31:0]                  stat_drops,
    output logic [31:0]                  stat_errors
`endif
);
    state_e state_q;
    logic [2:0] word_q;
    logic [30:0] rem_q;
    logic last_w4_q, header_valid_q, parse_error_q;
    logic [RDMA_OPCODE_WIDTH-1:0] op_sh_q, opcode_q;
    logic [OFFSET_LENGTH-1:0] off_sh_q, offset_q;
    logic [RDMA_ADDR_WIDTH-1:0] addr_sh_q, addr_q;
    logic [RDMA_RKEY_WIDTH-1:0] rkey_sh_q, rkey_q;
    logic [RDMA_LENGTH_WIDTH-1:0] length_q;
    logic [32:0] beats_w;
    logic final_w, s_hs_w, wr_go_w, unused_keep_w;
    logic [3:0] keep_last_w;
    assign unused_keep_w = ^s_axis_rx_tkeep;
    assign beats_w = {1'b0, length_q} + 33'd3;
    assign final_w = rem_q == 31'd1;
    assign s_hs_w = s_axis_rx_tvalid && s_axis_rx_tready;
    assign wr_go_w = is_write_opcode(opcode_q) && length_q != '0;
    assign keep_last_w = length_q[1:0] == 2'd0 ? 4'hF : length_q[1:0] == 2'd1 ? 4'h1 :
                         length_q[1:0] == 2'd2 ? 4'h3 : 4'h7;
    assign s_axis_rx_tready = aresetn && (state_q == ST_HDR || state_q == ST_DRAIN ||
                              (state_q == ST_PAYLOAD && m_axis_s2mm_tready));
    // Payload path is purely combinational so forwarding adds no latency
    assign m_axis_s2mm_tvalid = state_q == ST_PAYLOAD && s_axis_rx_tvalid;
    assign m_axis_s2mm_tdata = s_axis_rx_tdata;
    assign m_axis_s2mm_tlast = state_q == ST_PAYLOAD && (final_w || s_axis_rx_tlast);
    assign m_axis_s2mm_tkeep = state_q != ST_PAYLOAD ? '0 : final_w ? keep_last_w : 4'hF;
    assign header_valid = header_valid_q;
    assign parse_error = parse_error_q;
    assign rdma_opcode = opcode_q;
    assign rdma_remote_addr = addr_q;
    assign rdma_rkey = rkey_q;
    assign rdma_length = length_q;
    assign fragment_offset = offset_q;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_HDR;
            word_q <= '0;
            rem_q <= '0;
            last_w4_q <= 1'b0;
            header_valid_q <= 1'b0;
            parse_error_q <= 1'b0;
            op_sh_q <= '0;
            off_sh_q <= '0;
            addr_sh_q <= '0;
            rkey_sh_q <= '0;
            opcode_q <= '0;
            offset_q <= '0;
            addr_q <= '0;
            rkey_q <= '0;
            length_q <= '0;
        end else begin
            header_valid_q <= 1'b0;
            parse_error_q <= 1'b0;
            case (state_q)
                ST_HDR: if (s_hs_w) begin
                    if (word_q == 3'(HDR_WORDS - 1)) begin
                        opcode_q <= op_sh_q;
                        offset_q <= off_sh_q;
                        addr_q <= addr_sh_q;
                        rkey_q <= rkey_sh_q;
                        length_q <= s_axis_rx_tdata;
                        last_w4_q <= s_axis_rx_tlast;
                        header_valid_q <= 1'b1;
                        word_q <= '0;
                        state_q <= ST_EMIT;
                    end else if (s_axis_rx_tlast) begin
                        parse_error_q <= 1'b1;
                        word_q <= '0;
                    end else begin
                        word_q <= word_q + 3'd1;
                        if (word_q == 3'd0) begin
                            op_sh_q <= s_axis_rx_tdata[OPCODE_MSB:OPCODE_LSB];
                            off_sh_q <= s_axis_rx_tdata[OFFSET_MSB:OFFSET_LSB];
                        end
                        if (word_q == 3'd1) addr_sh_q[63:32] <= s_axis_rx_tdata;
                        if (word_q == 3'd2) addr_sh_q[31:0] <= s_axis_rx_tdata;
                        if (word_q == 3'd3) rkey_sh_q <= s_axis_rx_tdata;
                    end
                end
                ST_EMIT: begin
                    rem_q <= 31'(beats_w >> 2);
                    state_q <= wr_go_w ? ST_PAYLOAD : last_w4_q ? ST_HDR : ST_DRAIN;
                end
                ST_PAYLOAD: if (s_hs_w) begin
                    rem_q <= rem_q - 31'd1;
                    if (final_w || s_axis_rx_tlast) begin
                        state_q <= (final_w && !s_axis_rx_tlast) ? ST_DRAIN : ST_HDR;
                        parse_error_q <= !(final_w && s_axis_rx_tlast);
                    end
                end
                ST_DRAIN: if (s_hs_w && s_axis_rx_tlast) state_q <= ST_HDR;
                default: state_q <= ST_HDR;
            endcase
        end
    end
`ifdef RX_PARSER_STATS_EN
    logic emit_w;
    logic [31:0] pkts_q, writes_q, drops_q, errors_q;
    assign emit_w = state_q == ST_EMIT;
    assign stat_pkts = pkts_q;
    assign stat_writes = writes_q;
    assign stat_drops = drops_q;
    assign stat_errors = errors_q;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkts_q <= '0;
            writes_q <= '0;
            drops_q <= '0;
            errors_q <= '0;
        end else begin
            if (emit_w && !(&pkts_q)) pkts_q <= pkts_q + 32'd1;
            if (emit_w && wr_go_w && !(&writes_q)) writes_q <= writes_q + 32'd1;
            if (emit_w && !is_write_opcode(opcode_q) && !(&drops_q)) drops_q <= drops_q + 32'd1;
            if (parse_error_q && !(&errors_q)) errors_q <= errors_q + 32'd1;
        end
    end
`endif
endmodule

// File: doc/rx_header_parser.md
# rx_header_parser

Front stage of the RDMA receive path. Accepts raw packets as a 32-bit AXI-Stream from the network side, parses a fixed 5-word RDMA header, and emits a one-cycle `header_valid` pulse with the decoded fields to the downstream S2MM command engine. For WRITE opcodes it forwards exactly `length` payload bytes to the Data Mover S2MM data stream with a correct final `tkeep` and `tlast`; otherwise it discards the payload.

## Interface
- `C_DATA_WIDTH`, 32: stream width; only 32 is supported.
- `RDMA_OPCODE_WIDTH`, 8: opcode field width.
- `RDMA_ADDR_WIDTH`, 64: remote address width.
- `RDMA_RKEY_WIDTH`, 32: rkey width.
- `RDMA_LENGTH_WIDTH`, 32: payload byte-count width.
- `OFFSET_LENGTH`, 16: fragment offset width.
- `aclk`  in  1  clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `s_axis_rx_tdata / tkeep / tvalid / tready / tlast`  in/in/in/out/in  32/4/1/1/1  network packet input.
- `m_axis_s2mm_tdata / tkeep / tvalid / tready / tlast`  out/out/out/in/out  32/4/1/1/1  payload output to the Data Mover.
- `header_valid`  out  1  one-cycle pulse; the field outputs are valid in this cycle.
- `rdma_opcode`  out  8  opcode.
- `rdma_remote_addr`  out  64  destination address.
- `rdma_rkey`  out  32  remote key.
- `rdma_length`  out  32  payload bytes.
- `fragment_offset`  out  16  fragment offset.
- `parse_error`  out  1  one-cycle pulse on a malformed packet.

## Operation
- Header words, in arrival order:
  - W0 = {opcode[31:24], rsvd[23:16], fragment_offset[15:0]}
  - W1 = addr[63:32]
  - W2 = addr[31:0]
  - W3 = rkey
  - W4 = length
- States and transitions:
  - HDR: `s_tready` = 1; a word counter of 0..4 latches the fields. On acceptance of W4, go to EMIT.
  - EMIT: one cycle, `header_valid` = 1, `s_tready` = 0.
    - Go to PAYLOAD if the opcode is a WRITE (0x06, 0x07, 0x08, 0x0A, 0x01) and length is nonzero.
    - Otherwise go to DRAIN.
    - If W4 carried `tlast`, go to HDR instead of DRAIN.
  - PAYLOAD: pass-through. `m_tvalid` = `s_tvalid`, `s_tready` = `m_tready`, `m_tdata` = `s_tdata`.
    - A beat counter runs to ceil(length/4).
    - On the final beat: `m_tlast` = 1 and `m_tkeep` = {4'hF, 4'h1, 4'h3, 4'h7}[length[1:0]]. Other beats: `m_tkeep` = 4'hF.
    - Final beat with input `tlast` goes to HDR; without `tlast` it goes to DRAIN and raises `parse_error`.
    - Input `tlast` before the final beat forwards that beat with `m_tlast` = 1, raises `parse_error`, and goes to HDR.
  - DRAIN: `s_tready` = 1 and beats are discarded until `tlast`, then go to HDR.
- `tlast` during W0..W3 raises `parse_error` and returns to HDR. No `header_valid` is issued.
- Length 0 with a WRITE opcode still pulses `header_valid`; no payload is forwarded.
- Field outputs hold their values from `header_valid` until the next header is latched.
- The beat counter is 31 bits, ceil(length/4) = (length+3)>>2 computed at 33 bits. There is no wrap.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - state goes to HDR and all counters clear;
  - `header_valid`, `parse_error`, `m_tvalid`, `m_tlast` = 0, `m_tkeep` = 0;
  - all field outputs = 0;
  - `s_tready` = 0 during reset.
- Reset mid-packet abandons the packet. The remainder is parsed as a new header; the upstream MAC must also be reset.
- `header_valid` is asserted on the cycle after the W4 handshake.
- The first payload beat is offered no earlier than 2 cycles after the W4 handshake.
- Payload has zero added latency (combinational pass-through). `m_tvalid` must not depend on `m_tready`.
- The `parse_error` pulse is registered and occurs 1 cycle after the offending handshake.

## Configuration
- `RX_PARSER_STATS_EN` defined: adds 32-bit saturating counters `stat_pkts`, `stat_writes`, `stat_drops`, `stat_errors` as outputs. They are cleared by reset and incremented on EMIT, EMIT-to-PAYLOAD, EMIT-to-DRAIN/HDR for non-WRITE opcodes, and `parse_error` respectively.
- Undefined: these ports and counters are absent. Functionality is otherwise identical.

## Structure
- Shared package `rdma_rx_pkg`:
  - opcode constants (WRITE_FIRST/MIDDLE/LAST/ONLY/TEST);
  - `HDR_WORDS` = 5;
  - header field bit positions;
  - an `is_write_opcode` function, also reused by the command engine.
- No sub-module; a single FSM plus counters.

## Test plan
- WRITE_ONLY, addr 0x0000_0000_1000_0000, length 16, `tlast` on word 4 of the payload:
  - `header_valid` asserts once with the fields;
  - 4 beats are output, `m_tkeep` = 0xF, `m_tlast` on beat 4.
- Length 7 with 2 payload beats: beat 2 has `m_tkeep` = 0x7 and `m_tlast` = 1. Random `m_tready` gaps lose no data.
- Opcode 0x04 with 8 payload beats: `header_valid` pulses, no `m_tvalid` appears, and all 8 beats are drained. The next packet is parsed correctly.
- `tlast` on W2: `parse_error` pulses, no `header_valid`, and a following good packet parses.
- Length 32 but `tlast` on beat 3:
  - beat 3 is output with `m_tlast`, and `parse_error` pulses;
  - a separate case with length 8 and 5 beats of data forwards 2 beats, drains 3, and pulses `parse_error`.
- `aresetn` dropped during PAYLOAD: outputs go to 0 immediately, without waiting for `aclk`. With the stats feature enabled, the counters read 0.
